// File: rtl/fir_out_decimator_if.sv
// Sample stream into the decimator and the kept-sample FIFO drain back out.
// The master drives samples and out_ready; the slave (the decimator) drives the FIFO side.
interface fir_out_decimator_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_en;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [LVL_W-1:0]             level;
  logic                         overflow;

  modport master (
    output in_data, in_en, out_ready,
    input  out_data, out_valid, level, overflow
  );

  modport slave (
    input  in_data, in_en, out_ready,
    output out_data, out_valid, level, overflow
  );
endinterface

// File: rtl/fir_out_decimator.sv
// FIR output stage: drops FILL warm-up samples, keeps 1 of DECIM, buffers in a FWFT FIFO.
// Define FIR_DEC_OVF_CNT_EN to add the saturating ovf_count drop counter port.
module fir_out_decimator #(
  parameter int DATA_WIDTH = 8,
  parameter int DECIM      = 4,
  parameter int PHASE      = 0,
  parameter int FILL       = 5,
  parameter int DEPTH      = 8,
  parameter int OVF_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  fir_out_decimator_if.slave   bus
`ifdef FIR_DEC_OVF_CNT_EN
  ,
  output logic [OVF_WIDTH-1:0] ovf_count
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int FILL_W = (FILL > 1) ? $clog2(FILL) : 1;
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [FILL_W-1:0] FILL_LAST  = FILL_W'(FILL - 1);
  localparam logic [PH_W-1:0]   PHASE_LAST = PH_W'(DECIM - 1);
  localparam logic [PH_W-1:0]   PHASE_SEL  = PH_W'(PHASE);
  localparam logic [LVL_W-1:0]  LVL_FULL   = LVL_W'(DEPTH);

  if (DECIM < 1 || PHASE < 0 || PHASE >= DECIM || FILL < 0 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 || OVF_WIDTH < 1) begin : g_bad_params
    $error("fir_out_decimator: illegal parameter combination");
  end

  typedef enum logic {WARMUP = 1'b0, RUN = 1'b1} state_t;
  localparam state_t RST_STATE = (FILL == 0) ? RUN : WARMUP;

  state_t                  state_q, state_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic                    overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic keep, pop, push, drop, full, out_valid;

  // Warm-up / decimation sequencing; only in_en advances the counters.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    phase_d = phase_q;
    keep    = 1'b0;
    if (bus.in_en) begin
      if (state_q == WARMUP) begin
        phase_d = '0;
        if (fill_q == FILL_LAST) begin
          state_d = RUN;
          fill_d  = '0;
        end else begin
          fill_d = fill_q + FILL_W'(1);
        end
      end else begin
        keep    = (phase_q == PHASE_SEL);
        phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PH_W'(1);
      end
    end
  end

  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  always_comb begin
    out_valid  = (level_q != '0);
    full       = (level_q == LVL_FULL);
    pop        = out_valid && bus.out_ready;
    push       = keep && (!full || pop);
    drop       = keep && full && !pop;
    overflow_d = drop;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d    = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RST_STATE;
      fill_q     <= '0;
      phase_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; entries beyond level are never exposed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;

`ifdef FIR_DEC_OVF_CNT_EN
  logic [OVF_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + OVF_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_count = ovf_cnt_q;
`endif

endmodule
